// File: rtl/spi_pkg.sv
// Shared types and defaults for the serial slave.
package spi_pkg;
  localparam int SPI_WIDTH = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;
endpackage

// File: rtl/spi_serial_slave_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, with one-clk rise/fall pulses.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise_o =  sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_serial_slave.sv
// SPI mode-0 slave: oversampled sclk/cs_n/mosi, MSB-first rx and tx shifting.
module spi_serial_slave
  import spi_pkg::*;
#(
  parameter int WIDTH       = SPI_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk_in,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             busy
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic mosi_s;

  spi_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-2:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic [WIDTH-1:0] rx_word;
  logic             pend_q, pend_d;
  logic             rx_valid_q;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(sclk_in), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  // cs_n idles high, so its chain resets to 1 and a held-low cs_n selects after reset.
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst_n(rst_n), .d_i(cs_n), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_q <= '0;
    else        mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s  = mosi_q[SYNC_STAGES-1];
  assign rx_word = {rx_shift_q, mosi_s};

  // cs_rise is the first cycle synchronised cs_n is high while ACTIVE; it beats any sclk edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    rx_data_d  = rx_data_q;
    pend_d     = 1'b0;
    tx_buf_d   = tx_load ? tx_data : tx_buf_q;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d    = ACTIVE;
          tx_shift_d = tx_buf_q;
          cnt_d      = '0;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d    = IDLE;
          cnt_d      = '0;
          rx_shift_d = '0;
          tx_shift_d = '0;
        end else if (sclk_rise) begin
          rx_shift_d = rx_word[WIDTH-2:0];
          if (cnt_q == LAST) begin
            cnt_d     = '0;
            rx_data_d = rx_word;
            pend_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (sclk_fall) begin
          if (cnt_q == '0) tx_shift_d = tx_buf_q;
          else             tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      tx_buf_q   <= '0;
      rx_data_q  <= '0;
      pend_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      tx_buf_q   <= tx_buf_d;
      rx_data_q  <= rx_data_d;
      pend_q     <= pend_d;
      rx_valid_q <= pend_q;
    end
  end

  assign busy     = (state_q == ACTIVE);
  assign miso_oe  = busy;
  assign miso     = busy & tx_shift_q[WIDTH-1];
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_serial_slave.sv
// Directed bench for spi_serial_slave at SYNC_STAGES 2 and 3 driven by one master.
module tb_spi_serial_slave;
  localparam int HP = 32;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0, tx_load = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       miso2, oe2, rxv2, busy2, miso3, oe3, rxv3, busy3;
  logic [7:0] rxd2, rxd3;

  int         tests = 0, fails = 0;
  logic [7:0] q2[$], q3[$];
  logic [7:0] m2, m3;
  int         lat2, lat3, b2, b3;

  spi_serial_slave #(.WIDTH(8), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .sclk_in(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso2), .miso_oe(oe2), .rx_data(rxd2), .rx_valid(rxv2),
    .tx_data(tx_data), .tx_load(tx_load), .busy(busy2));

  spi_serial_slave #(.WIDTH(8), .SYNC_STAGES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .sclk_in(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso3), .miso_oe(oe3), .rx_data(rxd3), .rx_valid(rxv3),
    .tx_data(tx_data), .tx_load(tx_load), .busy(busy3));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each rx_valid pulse consumes the oldest expected word.
  always @(negedge clk) begin
    if (rxv2 === 1'b1) begin
      if (q2.size() == 0) chk("rx2_spurious_valid", rxv2, 1'b0);
      else                chk("rx2_data", rxd2, q2.pop_front());
    end
    if (rxv3 === 1'b1) begin
      if (q3.size() == 0) chk("rx3_spurious_valid", rxv3, 1'b0);
      else                chk("rx3_data", rxd3, q3.pop_front());
    end
  end

  task automatic half();
    for (int c = 0; c < HP; c++) begin
      @(negedge clk);
      tx_load = 1'b0;
    end
  endtask

  task automatic send_bits(input logic [7:0] w, input int n, input bit ld, input logic [7:0] ldv,
                           output logic [7:0] o2, output logic [7:0] o3);
    o2 = '0;
    o3 = '0;
    for (int i = 0; i < n; i++) begin
      mosi = w[7-i];
      if (ld && i == 2) begin
        tx_data = ldv;
        tx_load = 1'b1;
      end
      half();
      o2 = {o2[6:0], miso2};
      o3 = {o3[6:0], miso3};
      sclk = 1'b1;
      half();
      sclk = 1'b0;
    end
  endtask

  task automatic send_word(input logic [7:0] w, input logic [7:0] expm, input bit ld,
                           input logic [7:0] ldv, input string tag);
    logic [7:0] o2, o3;
    q2.push_back(w);
    q3.push_back(w);
    send_bits(w, 8, ld, ldv, o2, o3);
    chk({tag, "_miso2"}, o2, expm);
    chk({tag, "_miso3"}, o3, expm);
  endtask

  task automatic sel();
    cs_n = 1'b0;
    half();
  endtask

  task automatic desel(input string tag);
    half();
    cs_n = 1'b1;
    half();
    chk({tag, "_drain2"}, q2.size(), 0);
    chk({tag, "_drain3"}, q3.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (4) @(negedge clk);
    chk("rst_rx_valid", rxv2, 1'b0);
    chk("rst_miso_oe", oe2, 1'b0);
    chk("rst_miso", miso2, 1'b0);
    chk("rst_busy", busy2, 1'b0);
    chk("rst_rx_data", rxd2, 8'h00);
    chk("rst_busy3", busy3, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sclk = ~sclk;
      half();
    end
    chk("desel_busy", busy2, 1'b0);
    chk("desel_oe", oe2, 1'b0);

    tx_data = 8'h3C;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    sel();
    chk("sel_busy", busy2, 1'b1);
    chk("sel_oe", oe2, 1'b1);
    send_word(8'hA5, 8'h3C, 1'b0, 8'h00, "single");
    desel("single");

    // Second word's miso must be the word loaded mid-way through the first.
    sel();
    send_word(8'h01, 8'h3C, 1'b1, 8'h80, "b2b_w1");
    send_word(8'hFF, 8'h80, 1'b0, 8'h00, "b2b_w2");
    desel("b2b");

    // Deselect lands in the same cycle as the 5th sclk fall.
    sel();
    send_bits(8'hC7, 5, 1'b0, 8'h00, m2, m3);
    cs_n = 1'b1;
    b2 = 0;
    b3 = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (busy2 === 1'b0 && b2 == 0) b2 = k;
      if (busy3 === 1'b0 && b3 == 0) b3 = k;
    end
    chk("abort_busy_lat2", b2, 3);
    chk("abort_busy_lat3", b3, 4);
    chk("abort_miso", miso2, 1'b0);
    chk("abort_oe", oe2, 1'b0);
    half();
    sel();
    send_word(8'h5A, 8'h80, 1'b0, 8'h00, "abort_next");
    desel("abort");

    sel();
    q2.push_back(8'h96);
    q3.push_back(8'h96);
    send_bits(8'h96, 7, 1'b0, 8'h00, m2, m3);
    mosi = 1'b0;
    half();
    sclk = 1'b1;
    lat2 = 0;
    lat3 = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (rxv2 === 1'b1 && lat2 == 0) lat2 = k;
      if (rxv3 === 1'b1 && lat3 == 0) lat3 = k;
    end
    for (int c = 0; c < HP - 12; c++) @(negedge clk);
    sclk = 1'b0;
    chk("latency_s2", lat2, 4);
    chk("latency_s3", lat3, 5);
    desel("latency");

    sel();
    send_bits(8'hE1, 4, 1'b0, 8'h00, m2, m3);
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", busy2, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_rx_data", rxd2, 8'h00);
    chk("midrst_rx_valid", rxv2, 1'b0);
    chk("midrst_miso", miso2, 1'b0);
    chk("midrst_oe", oe2, 1'b0);
    chk("midrst_busy", busy2, 1'b0);
    chk("midrst_busy3", busy3, 1'b0);
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    sel();
    send_word(8'hC3, 8'h00, 1'b0, 8'h00, "post_rst");
    desel("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_serial_slave.md
Name: spi_serial_slave

Overview:
Receiving end of the team's serial clock/data link. An upstream master drives sclk, cs_n and mosi. This block oversamples them on the system clock, synchronises them and detects sclk edges. It shifts mosi in MSB-first to produce parallel words, and shifts a preloaded parallel word out on miso (SPI mode 0). Throughput is sized for the team's serial clock generator at its default 32-clk half-period.

Parameters:
WIDTH, 8, bits per serial word
SYNC_STAGES, 2, flip-flops in each input synchroniser (min 2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
sclk_in  input  1  serial clock from master, asynchronous to clk
cs_n  input  1  active-low chip select from master, asynchronous
mosi  input  1  serial data in, asynchronous
miso  output  1  serial data out, equals tx shift MSB
miso_oe  output  1  high while selected (external tristate enable)
rx_data  output  WIDTH  last complete received word
rx_valid  output  1  one-clk pulse, new rx_data
tx_data  input  WIDTH  next word to transmit
tx_load  input  1  writes tx_data into tx buffer
busy  output  1  high while synchronised cs_n low

Behaviour:
- Reset (rst_n low, async): all synchroniser flops 1 for cs_n, 0 for sclk/mosi. State IDLE, bit count 0, shift regs 0, tx buffer 0. Outputs: rx_data 0, rx_valid 0, miso 0, miso_oe 0, busy 0.
- Sync: sclk_in, cs_n and mosi each pass through SYNC_STAGES flops. A registered previous-sclk flop gives rise = sync&~prev and fall = ~sync&prev, each one clk wide.
- Timing requirement: sclk high and low phases each >= SYNC_STAGES+2 clk cycles. The cs_n setup to the first sclk rise must be at least the same.
- States: IDLE, ACTIVE.
  - IDLE->ACTIVE on synchronised cs_n falling: tx_shift <= tx_buf, count <= 0, miso_oe/busy <= 1.
  - ACTIVE->IDLE on synchronised cs_n high: partial word discarded, count <= 0, no rx_valid, miso_oe/busy <= 0, miso <= 0.
  - Edges are ignored in IDLE.
- On rise (ACTIVE): rx_shift <= {rx_shift[WIDTH-2:0], mosi_sync}, count++.
  - When count was WIDTH-1: rx_data <= the completed word, rx_valid high the next cycle only, count <= 0.
  - rx_valid rises SYNC_STAGES+2 clk edges after the raw sclk rise.
- On fall (ACTIVE): if count==0, tx_shift <= tx_buf (next word MSB presented); else tx_shift shifts left by 1, LSB filled with 0.
- miso = tx_shift[WIDTH-1] while ACTIVE.
- Back-to-back words with no cs_n deassertion are supported with no gap bits.
- tx_load: tx_buf <= tx_data on any cycle, in any state. A reload in the same cycle uses the old tx_buf value. If tx_buf is not rewritten, the same word is retransmitted.
- Simultaneous events: synchronised cs_n high in the same cycle as a rise or fall causes the edge to be ignored (deselect wins).
- rx_data holds its value until the next complete word; there is no backpressure, and the consumer must take it on rx_valid.
- Reset mid-word: returns to reset values immediately; the in-flight word is lost.

Decomposition:
- Shared package spi_pkg: default WIDTH constant, IDLE/ACTIVE state enum.
- Sub-module sync_edge: SYNC_STAGES synchroniser plus rise/fall pulse outputs. Instantiated for sclk_in, and for cs_n (using its fall/rise as select/deselect). mosi uses the synchroniser output only.

Test Plan:
- Reset: hold rst_n low with cs_n=1 -> rx_valid=0, miso_oe=0, miso=0, busy=0; release and keep cs_n high with sclk toggling -> no rx_valid ever.
- Single word, sclk half-period 32 clk: tx_load 8'h3C, assert cs_n, send mosi 8'hA5 MSB-first -> one rx_valid pulse, rx_data=8'hA5, miso bits sampled on sclk rises = 0,0,1,1,1,1,0,0.
- Back-to-back: two words 8'h01 then 8'hFF with cs_n held low, tx_load 8'h80 between -> rx_valid twice (8'h01, 8'hFF); second miso word = 8'h80 with no gap bit.
- Abort: deassert cs_n after 5 rises -> no rx_valid, busy=0 within SYNC_STAGES+1 clk; next full word 8'h5A is received correctly starting from bit 7.
- Latency/boundary: measure raw last-sclk rise to rx_valid -> exactly SYNC_STAGES+2 clk edges; repeat with SYNC_STAGES=3.
- Async reset mid-word after 4 bits -> all outputs 0 immediately; a full word after release decodes correctly.
